wb_event_filter: RTL

WB_EVENT_FILTER -- requirements
Module: wb_event_filter

---
 rtl/wb_event_pkg.sv | 23 ++
 rtl/wb_event_fifo.sv | 56 +++++
 rtl/wb_event_filter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/wb_event_pkg.sv
// Shared types for the data-memory write event filter: dedup FSM encoding,
// event field widths and the event record layout.
package wb_event_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int TIME_W = 16;

  typedef enum logic {
    ARMED = 1'b0,
    HELD  = 1'b1
  } dedup_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [TIME_W-1:0] stamp;
  } event_t;

  localparam int EVENT_W         = $bits(event_t);
  localparam int EVENT_NOSTAMP_W = ADDR_W + DATA_W;

endpackage

// File: rtl/wb_event_fifo.sv
// Event FIFO with push/pop handshake and full/empty flags. The head word
// reads as zero while empty so the event outputs are clean after reset.
module wb_event_fifo
  import wb_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = EVENT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign pop_en  = pop && !empty;
  // A pop frees the slot the push lands in, so full+pop still accepts.
  assign push_en = push && (!full || pop_en);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/wb_event_filter.sv
// Captures deduplicated, address-windowed data-memory writes into an event FIFO.
// Define WB_EVENT_FILTER_STAMP_EN to store a free-running cycle stamp per event.
module wb_event_filter
  import wb_event_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] WIN_BASE = 30'd0,
  parameter logic [ADDR_W-1:0] WIN_MASK = 30'h3FFFFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [ADDR_W-1:0] ev_addr,
  output logic [DATA_W-1:0] ev_data,
  output logic [TIME_W-1:0] ev_time,
  output logic [15:0]       wr_cnt,
  output logic [7:0]        drop_cnt,
  output logic              overflow
);

  dedup_state_t      state;
  dedup_state_t      state_next;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;
  logic              write_det;
  logic              in_win;
  logic              capture;
  logic              pop;
  logic              push_ok;
  logic              drop;
  logic              full;
  logic              empty;

  always_comb begin
    state_next = ARMED;
    write_det  = 1'b0;
    if (wen) begin
      state_next = HELD;
      write_det  = (state == ARMED) || (addr != last_addr) || (data != last_data);
    end
  end

  assign in_win   = ((addr & WIN_MASK) == (WIN_BASE & WIN_MASK));
  assign capture  = write_det && in_win;
  assign ev_valid = !empty;
  assign pop      = ev_valid && ev_ready;
  assign push_ok  = capture && (!full || pop);
  assign drop     = capture && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ARMED;
      last_addr <= '0;
      last_data <= '0;
      wr_cnt    <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_next;
      if (write_det) begin
        last_addr <= addr;
        last_data <= data;
      end
      if (push_ok && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef WB_EVENT_FILTER_STAMP_EN
  localparam int FIFO_W = EVENT_W;

  logic [TIME_W-1:0] stamp;
  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;
  event_t            head_ev;

  always_ff @(posedge clk) begin
    if (!rst) stamp <= '0;
    else      stamp <= stamp + TIME_W'(1);
  end

  assign fifo_din = {addr, data, stamp};
  assign head_ev  = fifo_dout;
  assign ev_addr  = head_ev.addr;
  assign ev_data  = head_ev.data;
  assign ev_time  = head_ev.stamp;
`else
  localparam int FIFO_W = EVENT_NOSTAMP_W;

  logic [FIFO_W-1:0] fifo_din;
  logic [FIFO_W-1:0] fifo_dout;

  assign fifo_din = {addr, data};
  assign ev_addr  = fifo_dout[FIFO_W-1 -: ADDR_W];
  assign ev_data  = fifo_dout[DATA_W-1:0];
  assign ev_time  = '0;
`endif

  wb_event_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(FIFO_W)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_ok),
    .pop  (pop),
    .din  (fifo_din),
    .dout (fifo_dout),
    .full (full),
    .empty(empty)
  );

endmodule
